// File: rtl/clic_irq_arbiter.sv
// Shares one core interrupt handshake between N_TARGET CLIC targets: picks the best pending
// target, offers it to the core, and pre-empts an outstanding offer via kill when a better one appears.
module clic_irq_arbiter #(
    parameter int unsigned N_TARGET  = 2,
    parameter int unsigned SrcWidth  = 8,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2,
    localparam int unsigned TgtWidth = $clog2(N_TARGET)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_TARGET-1:0]                 tgt_valid_i,
    output logic [N_TARGET-1:0]                 tgt_ready_o,
    input  logic [N_TARGET-1:0][SrcWidth-1:0]   tgt_id_i,
    input  logic [N_TARGET-1:0][PrioWidth-1:0]  tgt_max_i,
    input  logic [N_TARGET-1:0][ModeWidth-1:0]  tgt_mode_i,
    input  logic [N_TARGET-1:0]                 tgt_kill_req_i,
    output logic [N_TARGET-1:0]                 tgt_kill_ack_o,
    output logic                                irq_valid_o,
    input  logic                                irq_ready_i,
    output logic [SrcWidth-1:0]                 irq_id_o,
    output logic [PrioWidth-1:0]                irq_max_o,
    output logic [ModeWidth-1:0]                irq_mode_o,
    output logic [TgtWidth-1:0]                 irq_tgt_o,
    output logic                                irq_kill_req_o,
    input  logic                                irq_kill_ack_i
);

    localparam int unsigned RankWidth = ModeWidth + PrioWidth;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [TgtWidth-1:0]   sel_q;
    logic [SrcWidth-1:0]   id_q;
    logic [PrioWidth-1:0]  max_q;
    logic [ModeWidth-1:0]  mode_q;

    logic                  any_valid;
    logic                  better;
    logic [TgtWidth-1:0]   best_idx;
    logic [RankWidth-1:0]  best_rank;
    logic [RankWidth-1:0]  cand_rank;
    logic [RankWidth-1:0]  held_rank;
    logic                  sel_valid;
    logic                  hs;
    logic                  latch;

    // Rank is {mode, max}; strict compare keeps the lowest index on a full tie.
    always_comb begin
        any_valid = 1'b0;
        better    = 1'b0;
        best_idx  = '0;
        best_rank = '0;
        cand_rank = '0;
        held_rank = {mode_q, max_q};
        for (int i = 0; i < N_TARGET; i++) begin
            cand_rank = {tgt_mode_i[i], tgt_max_i[i]};
            if (tgt_valid_i[i]) begin
                if (!any_valid || (cand_rank > best_rank)) begin
                    best_idx  = TgtWidth'(i);
                    best_rank = cand_rank;
                end
                any_valid = 1'b1;
                if ((TgtWidth'(i) != sel_q) && (cand_rank > held_rank)) begin
                    better = 1'b1;
                end
            end
        end
    end

    // Core handshake: an offer transfers on any cycle where irq_valid_o and irq_ready_i are both high;
    // the accept is forwarded only to the offered target, in that same cycle.
    always_comb begin
        state_d        = state_q;
        latch          = 1'b0;
        sel_valid      = tgt_valid_i[sel_q];
        irq_valid_o    = (state_q != ST_IDLE) && sel_valid;
        hs             = irq_valid_o && irq_ready_i;
        irq_kill_req_o = 1'b0;
        tgt_ready_o    = '0;
        tgt_kill_ack_o = tgt_kill_req_i;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    latch   = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                tgt_kill_ack_o[sel_q] = 1'b0;
                if (hs) begin
                    tgt_ready_o[sel_q] = 1'b1;
                    state_d            = ST_IDLE;
                end else if (!sel_valid) begin
                    state_d = ST_IDLE;
                end else if (tgt_kill_req_i[sel_q]) begin
                    irq_kill_req_o        = 1'b1;
                    tgt_kill_ack_o[sel_q] = irq_kill_ack_i;
                    if (irq_kill_ack_i) begin
                        state_d = ST_IDLE;
                    end
                end else if (better) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                irq_kill_req_o        = 1'b1;
                tgt_kill_ack_o[sel_q] = 1'b0;
                if (hs) begin
                    // Accept beat the kill: the interrupt is taken, nobody sees an ack.
                    tgt_ready_o[sel_q] = 1'b1;
                    state_d            = ST_IDLE;
                end else begin
                    tgt_kill_ack_o[sel_q] = tgt_kill_req_i[sel_q] && irq_kill_ack_i;
                    if (irq_kill_ack_i || !sel_valid) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            id_q    <= '0;
            max_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                sel_q  <= best_idx;
                id_q   <= tgt_id_i[best_idx];
                max_q  <= tgt_max_i[best_idx];
                mode_q <= tgt_mode_i[best_idx];
            end
        end
    end

    assign irq_id_o   = id_q;
    assign irq_max_o  = max_q;
    assign irq_mode_o = mode_q;
    assign irq_tgt_o  = sel_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Bench for clic_irq_arbiter: directed scenario tasks plus a random offer/accept loop,
// with accepted offers checked against an expected queue.
module tb_clic_irq_arbiter;

    localparam int N  = 2;
    localparam int SW = 8;
    localparam int PW = 8;
    localparam int MW = 2;
    localparam int TW = 1;
    localparam int EW = TW + SW + PW + MW;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      tgt_valid_i;
    logic [N-1:0]      tgt_ready_o;
    logic [N-1:0][SW-1:0] tgt_id_i;
    logic [N-1:0][PW-1:0] tgt_max_i;
    logic [N-1:0][MW-1:0] tgt_mode_i;
    logic [N-1:0]      tgt_kill_req_i;
    logic [N-1:0]      tgt_kill_ack_o;
    logic              irq_valid_o;
    logic              irq_ready_i;
    logic [SW-1:0]     irq_id_o;
    logic [PW-1:0]     irq_max_o;
    logic [MW-1:0]     irq_mode_o;
    logic [TW-1:0]     irq_tgt_o;
    logic              irq_kill_req_o;
    logic              irq_kill_ack_i;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    logic [N-1:0]  exp_rdy;

    clic_irq_arbiter #(
        .N_TARGET (N),
        .SrcWidth (SW),
        .PrioWidth(PW),
        .ModeWidth(MW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tgt_valid_i   (tgt_valid_i),
        .tgt_ready_o   (tgt_ready_o),
        .tgt_id_i      (tgt_id_i),
        .tgt_max_i     (tgt_max_i),
        .tgt_mode_i    (tgt_mode_i),
        .tgt_kill_req_i(tgt_kill_req_i),
        .tgt_kill_ack_o(tgt_kill_ack_o),
        .irq_valid_o   (irq_valid_o),
        .irq_ready_i   (irq_ready_i),
        .irq_id_o      (irq_id_o),
        .irq_max_o     (irq_max_o),
        .irq_mode_o    (irq_mode_o),
        .irq_tgt_o     (irq_tgt_o),
        .irq_kill_req_o(irq_kill_req_o),
        .irq_kill_ack_i(irq_kill_ack_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // scoreboard: every core handshake must match the oldest expected offer
    always @(negedge clk_i) begin
        if (!rst_i && irq_valid_o && irq_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL hs_unexpected tgt=%0d id=%0d", irq_tgt_o, irq_id_o);
            end else begin
                exp_e = exp_q.pop_front();
                if ({irq_tgt_o, irq_id_o, irq_max_o, irq_mode_o} !== exp_e) begin
                    bad++;
                    $display("FAIL hs_offer got=%h want=%h", {irq_tgt_o, irq_id_o, irq_max_o, irq_mode_o}, exp_e);
                end
                exp_rdy = '0;
                exp_rdy[exp_e[EW-1]] = 1'b1;
                total++;
                if (tgt_ready_o !== exp_rdy) begin
                    bad++;
                    $display("FAIL hs_ready got=%b want=%b", tgt_ready_o, exp_rdy);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic set_tgt(input int idx, input logic v, input logic [SW-1:0] id,
                           input logic [PW-1:0] mx, input logic [MW-1:0] md);
        tgt_valid_i[idx] = v;
        tgt_id_i[idx]    = id;
        tgt_max_i[idx]   = mx;
        tgt_mode_i[idx]  = md;
    endtask

    task automatic clear_inputs();
        tgt_valid_i    = '0;
        tgt_id_i       = '0;
        tgt_max_i      = '0;
        tgt_mode_i     = '0;
        tgt_kill_req_i = '0;
        irq_ready_i    = 1'b0;
        irq_kill_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        sample();
        total++;
        if ({irq_valid_o, irq_kill_req_o, tgt_ready_o, tgt_kill_ack_o} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0", {irq_valid_o, irq_kill_req_o, tgt_ready_o, tgt_kill_ack_o});
        end
        total++;
        if ({irq_tgt_o, irq_id_o, irq_max_o, irq_mode_o} !== '0) begin
            bad++;
            $display("FAIL reset_regs got=%h want=0", {irq_tgt_o, irq_id_o, irq_max_o, irq_mode_o});
        end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_offer();
        set_tgt(0, 1'b1, 8'd5, 8'd10, 2'd3);
        sample();
        total++;
        if (irq_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL t1_latency valid=%b want=0", irq_valid_o);
        end
        tick();
        sample();
        total++;
        if ({irq_valid_o, irq_id_o, irq_tgt_o} !== {1'b1, 8'd5, 1'b0}) begin
            bad++;
            $display("FAIL t1_offer valid=%b id=%0d tgt=%0d want 1/5/0", irq_valid_o, irq_id_o, irq_tgt_o);
        end
        exp_q.push_back({1'b0, 8'd5, 8'd10, 2'd3});
        tick();
        irq_ready_i = 1'b1;
        sample();
        tick();
        clear_inputs();
        sample();
        total++;
        if (irq_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL t1_idle valid=%b want=0", irq_valid_o);
        end
        tick();
    endtask

    task automatic test_rank();
        set_tgt(0, 1'b1, 8'd7, 8'd200, 2'd1);
        set_tgt(1, 1'b1, 8'd9, 8'd1, 2'd3);
        tick();
        sample();
        total++;
        if ({irq_tgt_o, irq_id_o, irq_kill_req_o} !== {1'b1, 8'd9, 1'b0}) begin
            bad++;
            $display("FAIL t2_mode tgt=%0d id=%0d kill=%b want 1/9/0", irq_tgt_o, irq_id_o, irq_kill_req_o);
        end
        exp_q.push_back({1'b1, 8'd9, 8'd1, 2'd3});
        tick();
        irq_ready_i = 1'b1;
        tick();
        clear_inputs();
        tick();
        set_tgt(0, 1'b1, 8'd3, 8'd50, 2'd2);
        set_tgt(1, 1'b1, 8'd4, 8'd50, 2'd2);
        tick();
        sample();
        total++;
        if ({irq_tgt_o, irq_id_o} !== {1'b0, 8'd3}) begin
            bad++;
            $display("FAIL t2_tie tgt=%0d id=%0d want 0/3", irq_tgt_o, irq_id_o);
        end
        tick();
        sample();
        total++;
        if (irq_kill_req_o !== 1'b0) begin
            bad++;
            $display("FAIL t2_tie_nokill kill=%b want=0", irq_kill_req_o);
        end
        exp_q.push_back({1'b0, 8'd3, 8'd50, 2'd2});
        tick();
        irq_ready_i = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_preempt();
        set_tgt(0, 1'b1, 8'd10, 8'd10, 2'd2);
        tick();
        set_tgt(1, 1'b1, 8'd20, 8'd20, 2'd2);
        sample();
        total++;
        if (irq_kill_req_o !== 1'b0) begin
            bad++;
            $display("FAIL t3_kill_early kill=%b want=0", irq_kill_req_o);
        end
        tick();
        sample();
        total++;
        if ({irq_kill_req_o, irq_valid_o} !== 2'b11) begin
            bad++;
            $display("FAIL t3_kill kill/valid=%b want=11", {irq_kill_req_o, irq_valid_o});
        end
        tick();
        irq_kill_ack_i = 1'b1;
        sample();
        total++;
        if (tgt_kill_ack_o !== 2'b00) begin
            bad++;
            $display("FAIL t3_noack got=%b want=00", tgt_kill_ack_o);
        end
        tick();
        irq_kill_ack_i = 1'b0;
        sample();
        total++;
        if ({irq_valid_o, irq_kill_req_o} !== 2'b00) begin
            bad++;
            $display("FAIL t3_idle valid/kill=%b want=00", {irq_valid_o, irq_kill_req_o});
        end
        tick();
        sample();
        total++;
        if ({irq_tgt_o, irq_id_o, irq_max_o} !== {1'b1, 8'd20, 8'd20}) begin
            bad++;
            $display("FAIL t3_reoffer tgt=%0d id=%0d max=%0d want 1/20/20", irq_tgt_o, irq_id_o, irq_max_o);
        end
        exp_q.push_back({1'b1, 8'd20, 8'd20, 2'd2});
        tick();
        irq_ready_i = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_kill_vs_ready();
        set_tgt(0, 1'b1, 8'd11, 8'd10, 2'd1);
        tick();
        set_tgt(1, 1'b1, 8'd12, 8'd20, 2'd1);
        tick();
        exp_q.push_back({1'b0, 8'd11, 8'd10, 2'd1});
        irq_ready_i       = 1'b1;
        irq_kill_ack_i    = 1'b1;
        tgt_kill_req_i[0] = 1'b1;
        sample();
        total++;
        if ({irq_kill_req_o, tgt_kill_ack_o} !== 3'b100) begin
            bad++;
            $display("FAIL t4_kill_ack kill=%b ack=%b want 1/00", irq_kill_req_o, tgt_kill_ack_o);
        end
        tick();
        clear_inputs();
        sample();
        total++;
        if ({irq_valid_o, irq_kill_req_o} !== 2'b00) begin
            bad++;
            $display("FAIL t4_idle valid/kill=%b want=00", {irq_valid_o, irq_kill_req_o});
        end
        tick();
    endtask

    task automatic test_withdraw();
        set_tgt(1, 1'b1, 8'd33, 8'd5, 2'd1);
        tick();
        tgt_valid_i[1] = 1'b0;
        irq_ready_i    = 1'b1;
        sample();
        total++;
        if ({irq_valid_o, tgt_ready_o} !== 3'b000) begin
            bad++;
            $display("FAIL t5_drop valid=%b ready=%b want 0/00", irq_valid_o, tgt_ready_o);
        end
        tick();
        irq_ready_i    = 1'b0;
        tgt_valid_i[1] = 1'b1;
        sample();
        total++;
        if (irq_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL t5_idle valid=%b want=0", irq_valid_o);
        end
        tick();
        sample();
        total++;
        if ({irq_valid_o, irq_tgt_o} !== 2'b11) begin
            bad++;
            $display("FAIL t5_rearm valid/tgt=%b want=11", {irq_valid_o, irq_tgt_o});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_kill_paths();
        set_tgt(1, 1'b1, 8'd44, 8'd7, 2'd2);
        tick();
        tgt_kill_req_i[0] = 1'b1;
        sample();
        total++;
        if ({tgt_kill_ack_o, irq_kill_req_o} !== 3'b010) begin
            bad++;
            $display("FAIL t6_free_ack ack=%b kill=%b want 01/0", tgt_kill_ack_o, irq_kill_req_o);
        end
        tick();
        tgt_kill_req_i = 2'b10;
        sample();
        total++;
        if ({tgt_kill_ack_o, irq_kill_req_o} !== 3'b001) begin
            bad++;
            $display("FAIL t6_pass_req ack=%b kill=%b want 00/1", tgt_kill_ack_o, irq_kill_req_o);
        end
        tick();
        irq_kill_ack_i = 1'b1;
        sample();
        total++;
        if (tgt_kill_ack_o !== 2'b10) begin
            bad++;
            $display("FAIL t6_pass_ack ack=%b want=10", tgt_kill_ack_o);
        end
        tick();
        irq_kill_ack_i = 1'b0;
        tgt_kill_req_i = '0;
        tick();
        sample();
        total++;
        if (irq_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL t6_reoffer valid=%b want=1", irq_valid_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        irq_ready_i = 1'b1;
        sample();
        total++;
        if ({irq_valid_o, irq_kill_req_o, tgt_ready_o, irq_tgt_o, irq_id_o, irq_max_o} !== '0) begin
            bad++;
            $display("FAIL t6_reset valid=%b kill=%b ready=%b tgt=%0d id=%0d max=%0d want all 0",
                     irq_valid_o, irq_kill_req_o, tgt_ready_o, irq_tgt_o, irq_id_o, irq_max_o);
        end
        tick();
        clear_inputs();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  v;
        logic [MW-1:0] md[N];
        logic [PW-1:0] mx[N];
        logic [SW-1:0] id[N];
        int win;
        for (int k = 0; k < 24; k++) begin
            v   = N'($urandom_range(1, 3));
            win = -1;
            for (int i = 0; i < N; i++) begin
                md[i] = MW'($urandom_range(0, 3));
                mx[i] = PW'($urandom_range(0, 3));
                id[i] = SW'($urandom_range(0, 255));
                set_tgt(i, v[i], id[i], mx[i], md[i]);
                if (v[i]) begin
                    if (win < 0) win = i;
                    else if (md[i] > md[win] || (md[i] == md[win] && mx[i] > mx[win])) win = i;
                end
            end
            exp_q.push_back({TW'(win), id[win], mx[win], md[win]});
            tick();
            irq_ready_i = 1'b1;
            tick();
            clear_inputs();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_offer();
        test_rank();
        test_preempt();
        test_kill_vs_ready();
        test_withdraw();
        test_kill_paths();
        test_back_to_back();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
